// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg
// Shared definitions for the DDS waveform generator:
//   - MODE_* : waveform select codes driven on the Mode input
//   - max_value()    : positive full-scale value of a signed sample of a given width
//   - quarter_sine() : one entry of the quarter-wave sine table. It is evaluated
//                      at elaboration time only and folds to constants.
package wave_gen_pkg;

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  function automatic int max_value(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  // Entries are sampled at the middle of each table step (i + 0.5).
  // Reading the table backwards then gives the mirrored quarter exactly,
  // which makes the second and fourth quadrants cost nothing extra.
  function automatic int quarter_sine(input int i, input int data_w, input int lut_aw);
    real angle;
    real mag;
    angle = 3.141592653589793 / 2.0 * (real'(i) + 0.5) / real'(1 << lut_aw);
    mag   = real'(max_value(data_w)) * $sin(angle);
    return $rtoi(mag + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom
// Combinational quarter-wave sine magnitude table.
// Ports:
//   idx : table address (LUT_AW bits)
//   mag : unsigned magnitude, 0..2^(DATA_W-1)-1 (DATA_W-1 bits)
module sine_quarter_rom
  import wave_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] idx,
  output logic [DATA_W-2:0] mag
);

  logic [DATA_W-2:0] table_q [2**LUT_AW];

  // Each entry is a constant computed at elaboration time.
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_entry
    localparam int VALUE = quarter_sine(i, DATA_W, LUT_AW);
    assign table_q[i] = VALUE[DATA_W-2:0];
  end

  assign mag = table_q[idx];

endmodule

// File: rtl/wave_gen_dds.sv
// wave_gen_dds
// Direct-digital-synthesis test-signal generator: a phase accumulator followed
// by a three-stage pipeline (capture, waveform, amplitude scale).
// Ports:
//   Clk, Rst     : clock (rising edge) and asynchronous active-high reset
//   En           : capture one sample on this edge
//   Sync_clr     : restart the phase at zero (the sample captured with it starts at phase 0)
//   Mode         : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   Tune         : unsigned phase increment per sample
//   Amp          : unsigned amplitude scale (Amp/2^DATA_W)
//   data_out     : signed sample, holds its value between valid samples
//   data_valid   : data_out carries a new sample this cycle
//   cycle_start  : the valid sample is the first of a new waveform period
module wave_gen_dds
  import wave_gen_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               Sync_clr,
  input  logic [1:0]         Mode,
  input  logic [PHASE_W-1:0] Tune,
  input  logic [DATA_W-1:0]  Amp,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid,
  output logic               cycle_start
);

  localparam int MAXV = max_value(DATA_W);
  localparam logic [DATA_W-1:0] POS_FULL = DATA_W'(MAXV);
  localparam logic [DATA_W-1:0] NEG_FULL = DATA_W'(-MAXV);
  // Only the top phase bits reach the waveform stage; keep just as many as
  // the widest consumer (triangle or sine addressing) needs.
  localparam int P1_W = (DATA_W + 1 > LUT_AW + 2) ? DATA_W + 1 : LUT_AW + 2;

  logic [PHASE_W-1:0] acc;
  logic               wrap;
  logic [PHASE_W-1:0] base;
  logic [PHASE_W:0]   sum;

  logic [P1_W-1:0]    p1;
  logic [1:0]         mode1;
  logic [DATA_W-1:0]  amp1;
  logic               v1;
  logic               c1;

  logic [DATA_W-1:0]  raw;
  logic [DATA_W-1:0]  amp2;
  logic               v2;
  logic               c2;

  assign base = Sync_clr ? '0 : acc;
  assign sum  = {1'b0, base} + {1'b0, Tune};

  // Stage 1: capture the phase and the controls together so that a change
  // on Mode/Amp/Tune only ever affects whole samples. The carry out of the
  // accumulator marks the next sample as the start of a new period.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc   <= '0;
      wrap  <= 1'b1;
      p1    <= '0;
      mode1 <= '0;
      amp1  <= '0;
      v1    <= 1'b0;
      c1    <= 1'b0;
    end else begin
      v1 <= En;
      if (En) begin
        p1    <= base[PHASE_W-1 -: P1_W];
        mode1 <= Mode;
        amp1  <= Amp;
        c1    <= wrap | Sync_clr;
        acc   <= sum[PHASE_W-1:0];
        wrap  <= sum[PHASE_W];
      end else if (Sync_clr) begin
        acc  <= '0;
        wrap <= 1'b1;
      end
    end
  end

  logic [1:0]        quad;
  logic [LUT_AW-1:0] lut_idx;
  logic [LUT_AW-1:0] rom_idx;
  logic [DATA_W-2:0] rom_mag;
  logic [DATA_W-1:0] sine_pos;
  logic [DATA_W-1:0] sine_val;
  logic [DATA_W:0]   tri_t;
  logic [DATA_W-1:0] tri_u;
  logic [DATA_W-1:0] tri_val;
  logic [DATA_W-1:0] saw_top;
  logic [DATA_W-1:0] saw_val;
  logic [DATA_W-1:0] sq_val;
  logic [DATA_W-1:0] wave;

  assign quad    = p1[P1_W-1 -: 2];
  assign lut_idx = p1[P1_W-3 -: LUT_AW];
  // Odd quadrants read the table backwards, the lower half-cycle negates it.
  assign rom_idx = quad[0] ? ~lut_idx : lut_idx;

  sine_quarter_rom #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_rom (
    .idx (rom_idx),
    .mag (rom_mag)
  );

  assign sine_pos = {1'b0, rom_mag};
  assign sine_val = quad[1] ? -sine_pos : sine_pos;

  // Triangle folds the upper half of the ramp back down; inverting the MSB
  // turns the offset-binary ramp into a signed value.
  assign tri_t   = p1[P1_W-1 -: DATA_W+1];
  assign tri_u   = tri_t[DATA_W] ? ~tri_t[DATA_W-1:0] : tri_t[DATA_W-1:0];
  assign tri_val = {~tri_u[DATA_W-1], tri_u[DATA_W-2:0]};

  assign saw_top = p1[P1_W-1 -: DATA_W];
  assign saw_val = {~saw_top[DATA_W-1], saw_top[DATA_W-2:0]};

  assign sq_val  = p1[P1_W-1] ? NEG_FULL : POS_FULL;

  // Waveform select for stage 2.
  always_comb begin
    wave = sine_val;
    case (mode1)
      MODE_SINE:   wave = sine_val;
      MODE_SQUARE: wave = sq_val;
      MODE_TRI:    wave = tri_val;
      default:     wave = saw_val;
    endcase
  end

  // Stage 2: register the raw waveform sample alongside its qualifiers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      raw  <= '0;
      amp2 <= '0;
      v2   <= 1'b0;
      c2   <= 1'b0;
    end else begin
      raw  <= wave;
      amp2 <= amp1;
      v2   <= v1;
      c2   <= c1;
    end
  end

  // Signed sample times unsigned amplitude; the magnitude never exceeds
  // 2^(2*DATA_W-1), so a 2*DATA_W signed product is wide enough.
  logic signed [2*DATA_W-1:0] product;
  assign product = $signed(raw) * $signed({1'b0, amp2});

  // Stage 3: scale with an arithmetic shift (rounds toward minus infinity)
  // and hold the last sample while no new one arrives.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      data_valid  <= v2;
      cycle_start <= v2 & c2;
      if (v2) begin
        data_out <= DATA_W'(product >>> DATA_W);
      end
    end
  end

endmodule
